// File: rtl/fifo72_wr_gate.sv
// Write-side gate from an XGMII RX formatter into a 72-bit PHY queue FIFO.
// Optional statistics counters are enabled by defining L2SW_GATE_STATS_EN.
module fifo72_wr_gate #(
  parameter logic [9:0] MAX_WORDS = 10'd192
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [71:0] in_data,
  input  logic        fifo_full,
  output logic [71:0] fifo_din,
  output logic        fifo_wr_en,
  output logic        busy,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_drops,
  output logic [31:0] stat_truncs
);

  localparam logic [71:0] IDLE_WORD = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] ERR_WORD  = {8'hFF, 56'h07070707070707, 8'hFE};
  localparam logic [9:0]  LAST_CNT  = MAX_WORDS - 10'd1;

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_ABORT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [71:0] r_q;
  logic [9:0]  wcnt_q, wcnt_d;
  logic        eof_seen_q, eof_seen_d;

  logic       is_start;
  logic       is_term;
  logic [7:0] term_lane;
  logic       pass_term_ok;
  logic       pass_cut;

  assign is_start = r_q[64] && (r_q[7:0] == 8'hFB);

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign term_lane[gi] = r_q[64+gi] && (r_q[8*gi +: 8] == 8'hFD);
  end
  assign is_term = |term_lane;

  // A writable terminate always closes the frame, even at the word limit.
  assign pass_term_ok = is_term && !fifo_full;
  assign pass_cut     = !pass_term_ok && (fifo_full || (wcnt_q == LAST_CNT) || is_start);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_q        <= IDLE_WORD;
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      eof_seen_q <= 1'b0;
    end else begin
      r_q        <= in_data;
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      eof_seen_q <= eof_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    eof_seen_d = eof_seen_q;
    case (state_q)
      S_IDLE: begin
        if (is_start) begin
          if (!fifo_full) begin
            state_d = S_PASS;
            wcnt_d  = 10'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_PASS: begin
        if (pass_term_ok) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (pass_cut) begin
          state_d    = S_ABORT;
          wcnt_d     = '0;
          eof_seen_d = is_term;
        end else begin
          wcnt_d = wcnt_q + 10'd1;
        end
      end
      S_ABORT: begin
        // The frame's own terminate may already have passed; then skip DROP.
        if (!fifo_full) begin
          state_d    = (eof_seen_q || is_term) ? S_IDLE : S_DROP;
          eof_seen_d = 1'b0;
        end else begin
          eof_seen_d = eof_seen_q || is_term;
        end
      end
      S_DROP: begin
        if (is_term) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_din   = r_q;
    fifo_wr_en = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  fifo_wr_en = is_start && !fifo_full;
      S_PASS:  fifo_wr_en = !pass_cut;
      S_ABORT: begin
        fifo_din   = ERR_WORD;
        fifo_wr_en = !fifo_full;
      end
      default: fifo_wr_en = 1'b0;
    endcase
  end

`ifdef L2SW_GATE_STATS_EN
  logic        inc_frame, inc_drop, inc_trunc;
  logic [31:0] frames_q, frames_d;
  logic [31:0] drops_q, drops_d;
  logic [31:0] truncs_q, truncs_d;

  assign inc_frame = (state_q == S_PASS) && pass_term_ok;
  assign inc_drop  = (state_q == S_IDLE) && is_start && fifo_full;
  assign inc_trunc = (state_q == S_PASS) && pass_cut;

  always_comb begin
    frames_d = frames_q + {31'd0, inc_frame};
    drops_d  = drops_q + {31'd0, inc_drop};
    truncs_d = truncs_q + {31'd0, inc_trunc};
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      frames_q <= '0;
      drops_q  <= '0;
      truncs_q <= '0;
    end else begin
      frames_q <= frames_d;
      drops_q  <= drops_d;
      truncs_q <= truncs_d;
    end
  end

  assign stat_frames = frames_q;
  assign stat_drops  = drops_q;
  assign stat_truncs = truncs_q;
`else
  assign stat_frames = 32'h0;
  assign stat_drops  = 32'h0;
  assign stat_truncs = 32'h0;
`endif

endmodule

// File: tb/tb_fifo72_wr_gate.sv
// Scoreboard bench for fifo72_wr_gate: expected FIFO writes are queued as
// frames are driven and compared as the DUT asserts fifo_wr_en.
module tb_fifo72_wr_gate;

  localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] ERR_W  = {8'hFF, 56'h07070707070707, 8'hFE};

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [71:0] in_data = IDLE_W;
  logic        fifo_full = 1'b0;
  logic [71:0] fifo_din;
  logic        fifo_wr_en;
  logic        busy;
  logic [31:0] stat_frames, stat_drops, stat_truncs;

  fifo72_wr_gate dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .in_data    (in_data),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .busy       (busy),
    .stat_frames(stat_frames),
    .stat_drops (stat_drops),
    .stat_truncs(stat_truncs)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [71:0] exp_q[$];
  logic [71:0] mon_exp;
  int          extra_wr = 0;
  int          first_wr_cyc = -1;
  int          start_cyc = 0;
  bit          full_pend = 1'b0;
  int          exp_frames = 0, exp_drops = 0, exp_truncs = 0;
  logic [71:0] fr[$];
  bit          fl[$];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Counters only exist when the stats build option is enabled.
  function automatic logic [71:0] es(input int v);
    logic [71:0] r;
    r = 72'(v);
`ifndef L2SW_GATE_STATS_EN
    r = '0;
`endif
    return r;
  endfunction

  always @(negedge sys_clk) begin
    if (fifo_wr_en) begin
      check("wr_while_full", {71'd0, fifo_full}, 72'd0);
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        extra_wr++;
      end else begin
        mon_exp = exp_q.pop_front();
        check("fifo_din", fifo_din, mon_exp);
      end
    end
  end

  // fifo_full given with a word applies to the cycle that word sits in R.
  task automatic drive(input logic [71:0] w, input bit full, input bit rst);
    @(posedge sys_clk);
    #1;
    in_data   = w;
    fifo_full = full_pend;
    full_pend = full;
    sys_rst_n = !rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(IDLE_W, 1'b0, 1'b0);
  endtask

  task automatic add_frame(input int n);
    fr.push_back({8'h01, 24'($urandom), $urandom, 8'hFB});
    for (int j = 1; j < n - 1; j++) fr.push_back({8'h00, $urandom, $urandom});
    fr.push_back({8'hF8, 32'h07070707, 8'hFD, 24'($urandom)});
    for (int j = 0; j < n; j++) fl.push_back(1'b0);
  endtask

  task automatic clear_frame();
    fr.delete();
    fl.delete();
  endtask

  task automatic expect_range(input int a, input int b);
    for (int k = a; k <= b; k++) exp_q.push_back(fr[k]);
  endtask

  task automatic play(input int rst_idx);
    for (int i = 0; i < fr.size(); i++) begin
      drive(fr[i], fl[i], i == rst_idx);
      if (i == 0) start_cyc = cyc;
      if (rst_idx >= 0 && i == rst_idx + 1) begin
        @(negedge sys_clk);
        check("rst_wr_en", {71'd0, fifo_wr_en}, 72'd0);
        check("rst_busy", {71'd0, busy}, 72'd0);
        check("rst_din", fifo_din, IDLE_W);
        check("rst_frames", {40'd0, stat_frames}, 72'd0);
        check("rst_truncs", {40'd0, stat_truncs}, 72'd0);
      end
    end
  endtask

  task automatic finish_test(input string name);
    idle(6);
    check({name, "_q_empty"}, 72'(exp_q.size()), 72'd0);
    check({name, "_extra_wr"}, 72'(extra_wr), 72'd0);
    check({name, "_frames"}, {40'd0, stat_frames}, es(exp_frames));
    check({name, "_drops"}, {40'd0, stat_drops}, es(exp_drops));
    check({name, "_truncs"}, {40'd0, stat_truncs}, es(exp_truncs));
    $display("[TB] test %s done at cycle %0d", name, cyc);
    exp_q.delete();
    extra_wr = 0;
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_wr_en", {71'd0, fifo_wr_en}, 72'd0);
    check("reset_busy", {71'd0, busy}, 72'd0);
    check("reset_din", fifo_din, IDLE_W);
    check("reset_frames", {40'd0, stat_frames}, 72'd0);
    check("reset_drops", {40'd0, stat_drops}, 72'd0);
    check("reset_truncs", {40'd0, stat_truncs}, 72'd0);
    #1 sys_rst_n = 1'b1;
    idle(3);

    // Clean 9-word frame
    clear_frame();
    add_frame(9);
    expect_range(0, 8);
    first_wr_cyc = -1;
    play(-1);
    exp_frames++;
    finish_test("clean");
    check("latency", 72'(first_wr_cyc - start_cyc), 72'd1);

    // Start word meets a full FIFO: whole frame dropped
    clear_frame();
    add_frame(9);
    fl[0] = 1'b1;
    play(-1);
    exp_drops++;
    drive(IDLE_W, 1'b0, 1'b0);
    @(negedge sys_clk);
    check("drop_busy_at_fd", {71'd0, busy}, 72'd1);
    drive(IDLE_W, 1'b0, 1'b0);
    @(negedge sys_clk);
    check("drop_busy_after", {71'd0, busy}, 72'd0);
    finish_test("start_blocked");

    // Full for 3 cycles at word 4, then a normal frame
    clear_frame();
    add_frame(9);
    fl[4] = 1'b1;
    fl[5] = 1'b1;
    fl[6] = 1'b1;
    expect_range(0, 3);
    exp_q.push_back(ERR_W);
    play(-1);
    exp_truncs++;
    idle(2);
    clear_frame();
    add_frame(9);
    expect_range(0, 8);
    play(-1);
    exp_frames++;
    finish_test("mid_full");

    // Oversize frame cut at MAX_WORDS-1 words plus error word
    clear_frame();
    add_frame(250);
    expect_range(0, 190);
    exp_q.push_back(ERR_W);
    play(-1);
    exp_truncs++;
    finish_test("oversize");

    // Back-to-back frames, no idle between
    clear_frame();
    add_frame(8);
    add_frame(8);
    expect_range(0, 15);
    play(-1);
    exp_frames += 2;
    finish_test("back2back");

    // Terminate word meets full: truncated, error word, straight back to idle
    clear_frame();
    add_frame(5);
    fl[4] = 1'b1;
    expect_range(0, 3);
    exp_q.push_back(ERR_W);
    play(-1);
    exp_truncs++;
    idle(2);
    clear_frame();
    add_frame(6);
    expect_range(0, 5);
    play(-1);
    exp_frames++;
    finish_test("term_full");

    // Reset at word 5 of a frame, then a complete frame
    clear_frame();
    add_frame(9);
    expect_range(0, 4);
    exp_frames = 0;
    exp_drops = 0;
    exp_truncs = 0;
    play(5);
    idle(2);
    clear_frame();
    add_frame(9);
    expect_range(0, 8);
    play(-1);
    exp_frames++;
    finish_test("reset_mid");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
